pc_unit: RTL and testbench

- Parametrised program-counter generator for the rv32 pipeline front end, the successor to the basic PC register.
- Holds the fetch PC and presents it to fetch with a valid/ready handshake.
- Selects the next PC by priority: trap, resolved branch/jump from ALU, return-address-stack (RAS) prediction, sequential increment.
- Contains a circular RAS of RAS_DEPTH entries.

---
 rtl/pc_unit.sv | 104 ++++++++++
 tb/tb_pc_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch PC generator: trap > ALU redirect > RAS return > sequential; redirects land on pc after the edge.
// Backpressure: without fetch_ready the pc and RAS hold; trap and sel_pc redirect regardless.
module pc_unit #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fetch_ready,
  input  logic                           sel_pc,
  input  logic [XLEN-1:0]                in_alu,
  input  logic                           trap,
  input  logic [XLEN-1:0]                trap_vec,
  input  logic                           ras_push,
  input  logic                           ras_pop,
  output logic [XLEN-1:0]                pc,
  output logic [XLEN-1:0]                pc_nxt,
  output logic                           pc_valid,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC) - XLEN'(1));
  localparam logic [CW-1:0]   RAS_FULL   = CW'(RAS_DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic            ras_we;
  logic [PW-1:0]   ras_waddr;
  logic [PW-1:0]   top_ptr;
  logic            advance;
  logic            pop_ok;

  assign pc        = pc_q;
  assign pc_nxt    = pc_q + XLEN'(INC);
  assign pc_valid  = (state_q == RUN);
  assign ras_count = cnt_q;
  assign advance   = pc_valid && fetch_ready;
  assign top_ptr   = wptr_q - PW'(1);
  assign pop_ok    = ras_pop && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      wptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entries above ras_count are stale by design, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_waddr] <= pc_nxt;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_waddr = wptr_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap) begin
          pc_d  = trap_vec & ALIGN_MASK;
          cnt_d = '0;
        end else if (sel_pc) begin
          pc_d = in_alu & ALIGN_MASK;
        end else if (advance) begin
          pc_d = pop_ok ? ras_mem[top_ptr] : pc_nxt;
          if (ras_push && pop_ok) begin
            // Call-return pair: consume the top, then reuse its slot.
            ras_we    = 1'b1;
            ras_waddr = top_ptr;
          end else if (ras_push) begin
            ras_we = 1'b1;
            wptr_d = wptr_q + PW'(1);
            if (cnt_q != RAS_FULL) cnt_d = cnt_q + CW'(1);
          end else if (pop_ok) begin
            wptr_d = top_ptr;
            cnt_d  = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: queue-based reference model checked every cycle plus literal expectations.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready, sel_pc, trap, ras_push, ras_pop;
  logic [31:0] in_alu, trap_vec;
  logic [31:0] pc, pc_nxt;
  logic        pc_valid;
  logic [2:0]  ras_count;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: PC as a plain number, RAS as a bounded queue.
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_ras [$];

  pc_unit dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .sel_pc(sel_pc),
    .in_alu(in_alu), .trap(trap), .trap_vec(trap_vec), .ras_push(ras_push),
    .ras_pop(ras_pop), .pc(pc), .pc_nxt(pc_nxt), .pc_valid(pc_valid),
    .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [31:0] nxt;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_pc = 32'h0; m_valid = 1'b0; m_ras.delete();
      end else if (!m_valid) begin
        m_valid = 1'b1;
      end else if (trap) begin
        m_pc = trap_vec & ~32'h3; m_ras.delete();
      end else if (sel_pc) begin
        m_pc = in_alu & ~32'h3;
      end else if (fetch_ready) begin
        nxt = m_pc + 32'd4;
        if (ras_pop && m_ras.size() > 0) m_pc = m_ras.pop_back();
        else m_pc = nxt;
        if (ras_push) begin
          m_ras.push_back(nxt);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_pc", pc, m_pc);
        check("model_pc_nxt", pc_nxt, m_pc + 32'd4);
        check("model_valid", {31'b0, pc_valid}, {31'b0, m_valid});
        check("model_ras_count", {29'b0, ras_count}, m_ras.size());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    sel_pc = 1'b1; in_alu = tgt;
    step();
    sel_pc = 1'b0;
  endtask

  initial begin
    rst = 1'b0; fetch_ready = 1'b0; sel_pc = 1'b0; trap = 1'b0;
    ras_push = 1'b0; ras_pop = 1'b0; in_alu = '0; trap_vec = '0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pc", pc, 32'h0);
    check("reset_pc_nxt", pc_nxt, 32'h4);
    check("reset_valid", {31'b0, pc_valid}, 32'd0);
    check("reset_ras_count", {29'b0, ras_count}, 32'd0);

    // Boot: one cycle at pc 0 with valid low, then 0, 4, 8 on successive edges.
    rst = 1'b1; fetch_ready = 1'b1;
    check("boot_valid_low", {31'b0, pc_valid}, 32'd0);
    step();
    check("boot_pc0", pc, 32'h0);
    check("boot_valid_high", {31'b0, pc_valid}, 32'd1);
    step(); check("boot_pc4", pc, 32'h4);
    step(); check("boot_pc8", pc, 32'h8);
    step(); step(); check("seq_pc10", pc, 32'h10);

    // Stall then redirect while stalled.
    fetch_ready = 1'b0;
    repeat (3) step();
    check("stall_hold", pc, 32'h10);
    ras_push = 1'b1; step(); ras_push = 1'b0;
    check("stall_push_ignored", {29'b0, ras_count}, 32'd0);
    redirect(32'h8003);
    check("alu_aligned", pc, 32'h8000);

    // Priority: trap beats sel_pc and pop, and clears the RAS.
    fetch_ready = 1'b1; ras_push = 1'b1; step(); ras_push = 1'b0;
    check("pre_trap_count", {29'b0, ras_count}, 32'd1);
    trap = 1'b1; trap_vec = 32'h100; sel_pc = 1'b1; in_alu = 32'h8000; ras_pop = 1'b1;
    step();
    trap = 1'b0; sel_pc = 1'b0; ras_pop = 1'b0;
    check("trap_pc", pc, 32'h100);
    check("trap_ras_clear", {29'b0, ras_count}, 32'd0);

    // Call/return.
    redirect(32'h20);
    ras_push = 1'b1; step(); ras_push = 1'b0;
    redirect(32'h40);
    ras_push = 1'b1; step(); ras_push = 1'b0;
    check("call_count2", {29'b0, ras_count}, 32'd2);
    redirect(32'h200);
    ras_pop = 1'b1;
    step(); check("ret1", pc, 32'h44);
    step(); check("ret2", pc, 32'h24);
    step(); check("ret_empty_seq", pc, 32'h28);
    ras_pop = 1'b0;

    // Overflow: five calls, oldest dropped.
    for (int k = 0; k < 5; k++) begin
      redirect(32'h10 * k);
      ras_push = 1'b1; step(); ras_push = 1'b0;
    end
    check("ovf_count", {29'b0, ras_count}, 32'd4);
    ras_pop = 1'b1;
    step(); check("ovf_pop1", pc, 32'h44);
    step(); check("ovf_pop2", pc, 32'h34);
    step(); check("ovf_pop3", pc, 32'h24);
    step(); check("ovf_pop4", pc, 32'h14);
    step(); check("ovf_pop5_seq", pc, 32'h18);
    ras_pop = 1'b0;

    // Push and pop together on a non-empty stack replace the top.
    redirect(32'h60);
    ras_push = 1'b1; step();
    ras_pop = 1'b1; step();
    check("pushpop_pc", pc, 32'h64);
    check("pushpop_count", {29'b0, ras_count}, 32'd1);
    ras_push = 1'b0; step(); ras_pop = 1'b0;
    check("pushpop_ret", pc, 32'h68);

    // Wrap, then asynchronous reset mid-cycle.
    redirect(32'hFFFF_FFFC);
    check("wrap_pc_nxt", pc_nxt, 32'h0);
    step(); check("wrap_pc", pc, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_valid", {31'b0, pc_valid}, 32'd0);
    check("arst_count", {29'b0, ras_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    check("post_arst_pc", pc, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
